// File: rtl/jt053247_draw.sv
// Sprite slice renderer behind the 053246 scanner: fetches two ROM words per slice
// and writes the zoomed row into the line buffer. Define JT053247_ZOOM_EN for zoom.
module jt053247_draw #(
  parameter int PW    = 10,
  parameter int MAXPX = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dr_start,
  output logic          dr_busy,
  input  logic [15:0]   code,
  input  logic [PW-1:0] attr,
  input  logic          hflip,
  input  logic          vflip,
  input  logic [3:0]    ysub,
  input  logic [8:0]    hpos,
  input  logic [9:0]    hzoom,
  input  logic          hz_keep,
  output logic          rom_cs,
  output logic [20:0]   rom_addr,
  input  logic [31:0]   rom_data,
  input  logic          rom_ok,
  output logic          buf_we,
  output logic [8:0]    buf_addr,
  output logic [PW+3:0] buf_din
);
  localparam int CW = $clog2(MAXPX + 1);

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, DRAW} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] attr_q, attr_d;
  logic          hflip_q, hflip_d;
  logic          keep_q, keep_d;
  logic [8:0]    hpos_q, hpos_d;
  logic [63:0]   pix_q, pix_d;
  logic [9:0]    src_q, src_d;
  logic [8:0]    x_q, x_d;
  logic [8:0]    xsave_q, xsave_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          rom_cs_q, rom_cs_d;
  logic [20:0]   rom_addr_q, rom_addr_d;
  logic          buf_we_q, buf_we_d;
  logic [8:0]    buf_addr_q, buf_addr_d;
  logic [PW+3:0] buf_din_q, buf_din_d;

  logic [9:0]    step;
  logic [9:0]    residue;
  logic [10:0]   src_nx;
  logic [CW-1:0] cnt_nx;
  logic [3:0]    sidx;
  logic [3:0]    pen;

`ifdef JT053247_ZOOM_EN
  logic [9:0] hzoom_q, hzoom_d;
  logic [9:0] residue_q, residue_d;
  assign step    = (hzoom_q == 10'd0) ? 10'd1 : hzoom_q;
  assign residue = residue_q;
`else
  logic unused_hzoom;
  assign unused_hzoom = ^hzoom;
  assign step    = 10'h040;
  assign residue = 10'd0;
`endif

  // src carries 6 fractional bits; bit 10 of the sum flags the end of the 16-pixel row
  assign src_nx = {1'b0, src_q} + {1'b0, step};
  assign cnt_nx = cnt_q + CW'(1);
  assign sidx   = hflip_q ? ~src_q[9:6] : src_q[9:6];
  assign pen    = pix_q[{sidx, 2'b00} +: 4];

  always_comb begin
    state_d    = state_q;
    attr_d     = attr_q;
    hflip_d    = hflip_q;
    keep_d     = keep_q;
    hpos_d     = hpos_q;
    pix_d      = pix_q;
    src_d      = src_q;
    x_d        = x_q;
    xsave_d    = xsave_q;
    cnt_d      = cnt_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    buf_we_d   = 1'b0;
    buf_addr_d = buf_addr_q;
    buf_din_d  = buf_din_q;
`ifdef JT053247_ZOOM_EN
    hzoom_d    = hzoom_q;
    residue_d  = residue_q;
`endif
    case (state_q)
      IDLE: begin
        if (dr_start) begin
          state_d    = FETCH0;
          attr_d     = attr;
          hflip_d    = hflip;
          keep_d     = hz_keep;
          hpos_d     = hpos;
          rom_cs_d   = 1'b1;
          rom_addr_d = {code, ysub ^ {4{vflip}}, 1'b0};
`ifdef JT053247_ZOOM_EN
          hzoom_d    = hzoom;
`endif
        end
      end
      FETCH0: begin
        if (rom_ok) begin
          pix_d[31:0]   = rom_data;
          rom_addr_d[0] = 1'b1;
          state_d       = FETCH1;
        end
      end
      FETCH1: begin
        if (rom_ok) begin
          pix_d[63:32] = rom_data;
          rom_cs_d     = 1'b0;
          cnt_d        = '0;
          src_d        = keep_q ? residue : 10'd0;
          x_d          = keep_q ? xsave_q : hpos_q;
          state_d      = DRAW;
        end
      end
      DRAW: begin
        buf_we_d   = |pen;
        buf_addr_d = x_q;
        buf_din_d  = {attr_q, pen};
        x_d        = x_q + 9'd1;
        src_d      = src_nx[9:0];
        cnt_d      = cnt_nx;
        if (src_nx[10] || cnt_nx == CW'(MAXPX)) begin
          state_d = IDLE;
          xsave_d = x_q + 9'd1;
`ifdef JT053247_ZOOM_EN
          residue_d = src_nx[10] ? src_nx[9:0] : 10'd0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // stay busy through the cycle that shows the final pixel write
    busy_d = (state_d != IDLE) || (state_q == DRAW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      attr_q     <= '0;
      hflip_q    <= 1'b0;
      keep_q     <= 1'b0;
      hpos_q     <= '0;
      pix_q      <= '0;
      src_q      <= '0;
      x_q        <= '0;
      xsave_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_din_q  <= '0;
`ifdef JT053247_ZOOM_EN
      hzoom_q    <= '0;
      residue_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      attr_q     <= attr_d;
      hflip_q    <= hflip_d;
      keep_q     <= keep_d;
      hpos_q     <= hpos_d;
      pix_q      <= pix_d;
      src_q      <= src_d;
      x_q        <= x_d;
      xsave_q    <= xsave_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      buf_we_q   <= buf_we_d;
      buf_addr_q <= buf_addr_d;
      buf_din_q  <= buf_din_d;
`ifdef JT053247_ZOOM_EN
      hzoom_q    <= hzoom_d;
      residue_q  <= residue_d;
`endif
    end
  end

  assign dr_busy  = busy_q;
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign buf_we   = buf_we_q;
  assign buf_addr = buf_addr_q;
  assign buf_din  = buf_din_q;

endmodule

// File: tb/tb_jt053247_draw.sv
// Bench for jt053247_draw: directed and random slices against a pixel-list model
// derived from the zoom/flip/continuation rules, with a wait-state ROM responder.
module tb_jt053247_draw;
  localparam int PW    = 10;
  localparam int MAXPX = 256;
`ifdef JT053247_ZOOM_EN
  localparam bit ZOOM_EN = 1'b1;
`else
  localparam bit ZOOM_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dr_start = 1'b0;
  logic          dr_busy;
  logic [15:0]   code = '0;
  logic [PW-1:0] attr = '0;
  logic          hflip = 1'b0, vflip = 1'b0;
  logic [3:0]    ysub = '0;
  logic [8:0]    hpos = '0;
  logic [9:0]    hzoom = '0;
  logic          hz_keep = 1'b0;
  logic          rom_cs;
  logic [20:0]   rom_addr;
  logic [31:0]   rom_data;
  logic          rom_ok;
  logic          buf_we;
  logic [8:0]    buf_addr;
  logic [PW+3:0] buf_din;

  always #5 clk = ~clk;

  jt053247_draw #(.PW(PW), .MAXPX(MAXPX)) dut (
    .clk(clk), .rst(rst), .dr_start(dr_start), .dr_busy(dr_busy),
    .code(code), .attr(attr), .hflip(hflip), .vflip(vflip), .ysub(ysub),
    .hpos(hpos), .hzoom(hzoom), .hz_keep(hz_keep),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ROM responder: answers rom_delay cycles after a request, garbage until then
  logic [31:0] w0 = '0, w1 = '0;
  int rom_delay = 0;
  int wcnt = 0;
  assign rom_ok   = rom_cs && (wcnt >= rom_delay);
  assign rom_data = !rom_ok ? 32'hDEADBEEF : (rom_addr[0] ? w1 : w0);
  always @(posedge clk) wcnt <= (!rom_cs || rom_ok) ? 0 : wcnt + 1;

  logic [22:0] obs_q[$];
  logic [22:0] exp_q[$];
  logic [20:0] addr_q[$];
  int          busy_cnt = 0;
  logic        prev_cs = 1'b0, prev_ok = 1'b0;
  logic [20:0] prev_addr = '0;

  always @(negedge clk) begin
    if (buf_we) obs_q.push_back({buf_addr, buf_din});
    if (rom_cs && rom_ok) addr_q.push_back(rom_addr);
    if (dr_busy) busy_cnt++;
    if (rom_cs && prev_cs && !prev_ok) check("rom_addr_hold", rom_addr, prev_addr);
    prev_cs   = rom_cs;
    prev_ok   = rom_ok;
    prev_addr = rom_addr;
  end

  // Reference: walk source positions in 1/64 pixel units until 16.0 or MAXPX outputs
  logic [8:0] m_xsave = '0;
  int         m_res = 0;

  function automatic logic [3:0] src_pen(input int p);
    logic [31:0] w;
    w = (p < 8) ? w0 : w1;
    return 4'((w >> (4 * (p % 8))) & 32'hF);
  endfunction

  task automatic model(input logic [PW-1:0] a, input bit hf, input logic [8:0] hp,
                       input int hz, input bit keep, output int npix);
    int step, src, x, s, p;
    bit done;
    logic [3:0] pen;
    step = ZOOM_EN ? ((hz == 0) ? 1 : hz) : 64;
    src  = keep ? m_res : 0;
    x    = keep ? int'(m_xsave) : int'(hp);
    npix = 0;
    done = 1'b0;
    while (!done) begin
      s   = src / 64;
      p   = hf ? 15 - s : s;
      pen = src_pen(p);
      if (pen != 4'd0) exp_q.push_back({9'(x), a, pen});
      x = (x + 1) % 512;
      src += step;
      npix++;
      if (src >= 1024) begin
        m_res = ZOOM_EN ? src - 1024 : 0;
        done  = 1'b1;
      end else if (npix == MAXPX) begin
        m_res = 0;
        done  = 1'b1;
      end
    end
    m_xsave = 9'(x);
  endtask

  task automatic slice(input string tag, input logic [15:0] cd, input logic [PW-1:0] a,
                       input bit hf, input bit vf, input logic [3:0] ys, input logic [8:0] hp,
                       input logic [9:0] hz, input bit keep, input logic [31:0] lw0,
                       input logic [31:0] lw1, input int dly, input bit hold2);
    int npix, guard, nmin, cyc;
    logic [20:0] ea;
    w0 = lw0;
    w1 = lw1;
    rom_delay = dly;
    obs_q.delete();
    exp_q.delete();
    addr_q.delete();
    model(a, hf, hp, int'(hz), keep, npix);
    ea = 21'(int'(cd) * 32 + (vf ? 15 - int'(ys) : int'(ys)) * 2);
    @(negedge clk);
    busy_cnt = 0;
    code = cd; attr = a; hflip = hf; vflip = vf; ysub = ys;
    hpos = hp; hzoom = hz; hz_keep = keep;
    dr_start = 1'b1;
    @(negedge clk);
    if (hold2) @(negedge clk);
    dr_start = 1'b0;
    guard = 0;
    while (dr_busy && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_busy_end"}, dr_busy, 1'b0);
    cyc = 2 * (1 + dly) + npix + 1;
    check({tag, "_busy_cycles"}, busy_cnt, cyc);
    check({tag, "_rom_reqs"}, addr_q.size(), 2);
    if (addr_q.size() > 0) check({tag, "_addr0"}, addr_q[0], ea);
    if (addr_q.size() > 1) check({tag, "_addr1"}, addr_q[1], ea + 21'd1);
    check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) check({tag, "_write"}, obs_q[i], exp_q[i]);
    $display("slice %s: pixels=%0d writes=%0d busy=%0d", tag, npix, obs_q.size(), busy_cnt);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", dr_busy, 1'b0);
    check("rst_rom_cs", rom_cs, 1'b0);
    check("rst_rom_addr", rom_addr, 21'd0);
    check("rst_buf_we", buf_we, 1'b0);
    check("rst_buf_addr", buf_addr, 9'd0);
    check("rst_buf_din", buf_din, '0);
    rst = 1'b0;

    slice("one2one", 16'h1234, 10'h155, 0, 0, 4'd3, 9'h050, 10'h040, 0,
          32'h76543210, 32'hFEDCBA98, 0, 0);
    slice("flips", 16'h1234, 10'h155, 1, 1, 4'd3, 9'h050, 10'h040, 0,
          32'h76543210, 32'hFEDCBA98, 0, 0);
    slice("zoom80", 16'h0042, 10'h2AA, 0, 0, 4'd9, 9'h010, 10'h080, 0,
          32'h76543210, 32'hFEDCBA98, 0, 0);
    slice("zoom20", 16'h0043, 10'h0F0, 0, 1, 4'd0, 9'h020, 10'h020, 0,
          32'h76543210, 32'hFEDCBA98, 1, 0);
    slice("zoom0", 16'hBEEF, 10'h001, 1, 0, 4'd15, 9'h0C0, 10'h000, 0,
          32'h76543210, 32'hFEDCBA98, 0, 0);
    slice("cont_a", 16'h0100, 10'h123, 0, 0, 4'd5, 9'h100, 10'h030, 0,
          32'h76543210, 32'hFEDCBA98, 0, 0);
    slice("cont_b", 16'h0101, 10'h321, 0, 0, 4'd5, 9'h000, 10'h030, 1,
          32'h89ABCDEF, 32'h01234567, 0, 0);
    slice("wrap_hold", 16'h7FFF, 10'h3FF, 0, 0, 4'd7, 9'h1F8, 10'h040, 0,
          32'h76543210, 32'hFEDCBA98, 5, 1);

    // reset in the middle of a draw, then continue-mode must start from zero
    @(negedge clk);
    w0 = 32'h11111111; w1 = 32'h11111111; rom_delay = 0;
    code = 16'h0055; attr = 10'h0AA; hflip = 0; vflip = 0; ysub = 4'd1;
    hpos = 9'h040; hzoom = 10'h040; hz_keep = 0;
    dr_start = 1'b1;
    @(negedge clk);
    dr_start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_we", buf_we, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_we", buf_we, 1'b0);
    check("mid_rst_busy", dr_busy, 1'b0);
    check("mid_rst_cs", rom_cs, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_res = 0;
    m_xsave = '0;
    slice("after_rst", 16'h0056, 10'h0BB, 0, 0, 4'd2, 9'h123, 10'h050, 1,
          32'h76543210, 32'hFEDCBA98, 0, 0);

    for (int i = 0; i < 25; i++) begin
      slice($sformatf("rand%0d", i), 16'($urandom), PW'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom), 9'($urandom), 10'($urandom_range(8, 768)), 1'($urandom),
            $urandom, $urandom, $urandom_range(0, 3), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
